// File: rtl/dmux16_scan_seq.sv
// dmux16_scan_seq: sequences the select lines of a 1:16 demux through
// channels 0..15, holding each channel for DWELL cycles and driving the
// demux data input from a pattern captured when the scan starts.
// Supports one-shot and continuous scanning, abort, and busy/done status.
module dmux16_scan_seq #(
  parameter int unsigned DWELL = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        mode,
  input  logic        stop,
  input  logic [15:0] pattern,
  output logic        s0,
  output logic        s1,
  output logic        s2,
  output logic        s3,
  output logic        d0,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CHAN_W = 4;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DWELL - 1);
  localparam logic [CHAN_W-1:0] CHAN_LAST = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CHAN_W-1:0]   chan_q;
  logic [CHAN_W-1:0]   chan_nxt;
  logic [15:0]         pattern_q;
  logic                mode_q;

  // Next channel index, wrapping 15 -> 0 naturally in 4 bits.
  assign chan_nxt = chan_q + CHAN_W'(1);

  // Select lines come straight from the channel register.
  assign {s3, s2, s1, s0} = chan_q;

  // Scan sequencer: state, dwell counter, channel and all status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      chan_q    <= '0;
      pattern_q <= '0;
      mode_q    <= 1'b0;
      d0        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          chan_q <= '0;
          if (start) begin
            state_q   <= RUN;
            pattern_q <= pattern;
            mode_q    <= mode;
            d0        <= pattern[0];
            busy      <= 1'b1;
          end else begin
            d0   <= 1'b0;
            busy <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            // Abort wins over everything, including end of scan.
            state_q <= IDLE;
            cnt_q   <= '0;
            chan_q  <= '0;
            d0      <= 1'b0;
            busy    <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (chan_q == CHAN_LAST) begin
              chan_q <= '0;
              if (mode_q) begin
                // Continuous: wrap to channel 0 without a gap cycle.
                d0 <= pattern_q[0];
              end else begin
                done <= 1'b1;
                if (start) begin
                  // Relaunch in the completion cycle with a fresh capture.
                  pattern_q <= pattern;
                  mode_q    <= mode;
                  d0        <= pattern[0];
                end else begin
                  state_q <= IDLE;
                  d0      <= 1'b0;
                  busy    <= 1'b0;
                end
              end
            end else begin
              chan_q <= chan_nxt;
              d0     <= pattern_q[chan_nxt];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmux16_scan_seq.sv
// Bench for dmux16_scan_seq: three instances (DWELL 4, 2, 1) share clock
// and reset; each has its own inputs. Expected outputs come from a
// closed-form model of the scan timeline indexed by cycles since start.
module tb_dmux16_scan_seq;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start   [NI];
  logic        mode    [NI];
  logic        stop    [NI];
  logic [15:0] pattern [NI];
  logic        s0 [NI], s1 [NI], s2 [NI], s3 [NI];
  logic        d0 [NI], busy [NI], done [NI];

  int vectors = 0;
  int errors  = 0;

  dmux16_scan_seq #(.DWELL(4)) u_dw4 (
    .clk(clk), .rstn(rstn), .start(start[0]), .mode(mode[0]), .stop(stop[0]),
    .pattern(pattern[0]), .s0(s0[0]), .s1(s1[0]), .s2(s2[0]), .s3(s3[0]),
    .d0(d0[0]), .busy(busy[0]), .done(done[0]));

  dmux16_scan_seq #(.DWELL(2)) u_dw2 (
    .clk(clk), .rstn(rstn), .start(start[1]), .mode(mode[1]), .stop(stop[1]),
    .pattern(pattern[1]), .s0(s0[1]), .s1(s1[1]), .s2(s2[1]), .s3(s3[1]),
    .d0(d0[1]), .busy(busy[1]), .done(done[1]));

  dmux16_scan_seq #(.DWELL(1)) u_dw1 (
    .clk(clk), .rstn(rstn), .start(start[2]), .mode(mode[2]), .stop(stop[2]),
    .pattern(pattern[2]), .s0(s0[2]), .s1(s1[2]), .s2(s2[2]), .s3(s3[2]),
    .d0(d0[2]), .busy(busy[2]), .done(done[2]));

  always #5 clk = ~clk;

  function automatic int dw(int i);
    return (i == 0) ? 4 : (i == 1) ? 2 : 1;
  endfunction

  // Observed {busy, done, s[3:0], d0} of instance i.
  function automatic logic [6:0] obs(int i);
    return {busy[i], done[i], s3[i], s2[i], s1[i], s0[i], d0[i]};
  endfunction

  // Expected {busy, done, s[3:0], d0} after the k-th edge following start.
  function automatic logic [6:0] model(int d, logic [15:0] pat, logic m, int k);
    int c;
    if (m || k < 16 * d) begin
      c = (k / d) % 16;
      return {1'b1, 1'b0, 4'(c), pat[4'(c)]};
    end
    if (k == 16 * d) return 7'b0100000;
    return 7'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(int i, logic [15:0] p, logic m);
    pattern[i] = p;
    mode[i]    = m;
    start[i]   = 1'b1;
    tick();
    start[i]   = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NI; i++) start[i] = n[0];
      tick();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if (obs(i) !== 7'd0) begin
          errors++;
          $display("FAIL reset_hold inst=%0d n=%0d got=%b exp=%b", i, n, obs(i), 7'd0);
        end
      end
    end
    for (int i = 0; i < NI; i++) start[i] = 1'b0;
    rstn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if (obs(i) !== 7'd0) begin
          errors++;
          $display("FAIL reset_release inst=%0d n=%0d got=%b exp=%b", i, n, obs(i), 7'd0);
        end
      end
    end
  endtask

  task automatic test_oneshot();
    logic [15:0] pat;
    logic [6:0]  want;
    int i, d;
    for (int t = 0; t < 4; t++) begin
      i   = (t < 2) ? 0 : t - 1;
      d   = dw(i);
      pat = (t == 0) ? 16'hA5C3 : 16'($urandom);
      launch(i, pat, 1'b0);
      for (int k = 0; k <= 16 * d + 2; k++) begin
        want = model(d, pat, 1'b0, k);
        vectors++;
        if (obs(i) !== want) begin
          errors++;
          $display("FAIL oneshot inst=%0d pat=%h k=%0d got=%b exp=%b", i, pat, k, obs(i), want);
        end
        tick();
      end
    end
  endtask

  task automatic test_continuous();
    logic [15:0] pat;
    logic [6:0]  want;
    int i, d, len;
    for (int t = 0; t < 2; t++) begin
      i   = (t == 0) ? 1 : 2;
      d   = dw(i);
      len = (t == 0) ? 100 : 40;
      pat = 16'($urandom);
      launch(i, pat, 1'b1);
      for (int k = 0; k < len; k++) begin
        want = model(d, pat, 1'b1, k);
        vectors++;
        if (obs(i) !== want) begin
          errors++;
          $display("FAIL continuous inst=%0d pat=%h k=%0d got=%b exp=%b", i, pat, k, obs(i), want);
        end
        if (k == len - 1) stop[i] = 1'b1;
        tick();
      end
      stop[i] = 1'b0;
      vectors++;
      if (obs(i) !== 7'd0) begin
        errors++;
        $display("FAIL continuous_stop inst=%0d got=%b exp=%b", i, obs(i), 7'd0);
      end
    end
  endtask

  task automatic test_abort();
    logic [15:0] pat;
    logic [6:0]  want;
    logic        m;
    int i, d, ks;
    for (int t = 0; t < 4; t++) begin
      i   = (t < 2) ? 0 : t - 1;
      d   = dw(i);
      m   = (t == 3) ? 1'b1 : (t == 2) ? 1'($urandom) : 1'b0;
      ks  = (t == 0) ? 22 : (t == 1) ? 63 : int'($urandom_range(0, 40));
      pat = 16'($urandom);
      launch(i, pat, m);
      for (int k = 0; k <= ks; k++) begin
        want = model(d, pat, m, k);
        vectors++;
        if (obs(i) !== want) begin
          errors++;
          $display("FAIL abort_run inst=%0d ks=%0d k=%0d got=%b exp=%b", i, ks, k, obs(i), want);
        end
        if (k == ks) stop[i] = 1'b1;
        tick();
      end
      stop[i] = 1'b0;
      for (int n = 0; n < 2; n++) begin
        vectors++;
        if (obs(i) !== 7'd0) begin
          errors++;
          $display("FAIL abort_idle inst=%0d ks=%0d n=%0d got=%b exp=%b", i, ks, n, obs(i), 7'd0);
        end
        tick();
      end
    end
  endtask

  task automatic test_ignored();
    logic [15:0] p1, p2;
    logic [6:0]  want;
    int i, d;
    i = 1;
    d = dw(i);
    // stop alone in IDLE does nothing
    stop[i] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      vectors++;
      if (obs(i) !== 7'd0) begin
        errors++;
        $display("FAIL idle_stop n=%0d got=%b exp=%b", n, obs(i), 7'd0);
      end
    end
    // start and stop together in IDLE: start wins
    p1 = 16'($urandom);
    pattern[i] = p1;
    mode[i]    = 1'b0;
    start[i]   = 1'b1;
    tick();
    start[i] = 1'b0;
    stop[i]  = 1'b0;
    for (int k = 0; k <= 16 * d + 1; k++) begin
      want = model(d, p1, 1'b0, k);
      vectors++;
      if (obs(i) !== want) begin
        errors++;
        $display("FAIL start_stop k=%0d got=%b exp=%b", k, obs(i), want);
      end
      tick();
    end
    // start during a run is ignored, new pattern/mode not seen
    launch(i, 16'h0000, 1'b0);
    for (int k = 0; k <= 16 * d + 1; k++) begin
      if (k == 3) begin
        start[i]   = 1'b1;
        pattern[i] = 16'hFFFF;
        mode[i]    = 1'b1;
      end
      if (k == 9) start[i] = 1'b0;
      want = model(d, 16'h0000, 1'b0, k);
      vectors++;
      if (obs(i) !== want) begin
        errors++;
        $display("FAIL start_in_run k=%0d got=%b exp=%b", k, obs(i), want);
      end
      tick();
    end
    // start held through completion relaunches with done and busy together
    p1 = 16'($urandom);
    p2 = 16'($urandom);
    pattern[i] = p1;
    mode[i]    = 1'b0;
    start[i]   = 1'b1;
    tick();
    pattern[i] = p2;
    for (int k = 0; k <= 16 * d; k++) begin
      want = (k == 16 * d) ? {1'b1, 1'b1, 4'd0, p2[0]} : model(d, p1, 1'b0, k);
      vectors++;
      if (obs(i) !== want) begin
        errors++;
        $display("FAIL relaunch_a k=%0d got=%b exp=%b", k, obs(i), want);
      end
      if (k == 16 * d) start[i] = 1'b0;
      tick();
    end
    for (int k = 1; k <= 16 * d + 1; k++) begin
      want = model(d, p2, 1'b0, k);
      vectors++;
      if (obs(i) !== want) begin
        errors++;
        $display("FAIL relaunch_b k=%0d got=%b exp=%b", k, obs(i), want);
      end
      tick();
    end
  endtask

  task automatic test_dwell1_reset();
    logic [15:0] pat;
    logic [6:0]  want;
    pat = 16'($urandom);
    launch(2, pat, 1'b0);
    for (int k = 0; k <= 18; k++) begin
      want = model(1, pat, 1'b0, k);
      vectors++;
      if (obs(2) !== want) begin
        errors++;
        $display("FAIL dwell1 k=%0d got=%b exp=%b", k, obs(2), want);
      end
      tick();
    end
    // asynchronous reset while DWELL=4 instance sits on channel 9
    pat = 16'($urandom);
    launch(0, pat, 1'b0);
    for (int k = 0; k <= 37; k++) begin
      want = model(4, pat, 1'b0, k);
      vectors++;
      if (obs(0) !== want) begin
        errors++;
        $display("FAIL pre_reset k=%0d got=%b exp=%b", k, obs(0), want);
      end
      if (k < 37) tick();
    end
    #2;
    rstn = 1'b0;
    #1;
    vectors++;
    if (obs(0) !== 7'd0) begin
      errors++;
      $display("FAIL async_reset got=%b exp=%b", obs(0), 7'd0);
    end
    tick();
    #2;
    rstn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      vectors++;
      if (obs(0) !== 7'd0) begin
        errors++;
        $display("FAIL post_reset n=%0d got=%b exp=%b", n, obs(0), 7'd0);
      end
    end
    pat = 16'($urandom);
    launch(0, pat, 1'b0);
    want = model(4, pat, 1'b0, 0);
    vectors++;
    if (obs(0) !== want) begin
      errors++;
      $display("FAIL restart got=%b exp=%b", obs(0), want);
    end
  endtask

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start[i]   = 1'b0;
      mode[i]    = 1'b0;
      stop[i]    = 1'b0;
      pattern[i] = 16'h0000;
    end
    test_reset();
    test_oneshot();
    test_continuous();
    test_abort();
    test_ignored();
    test_dwell1_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
